// File: rtl/mem_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_fill_arbiter
// Brief    : N-port arbiter onto a fixed-latency pipelined memory; block fills
//            for reads, single-word write-through for writes.
// Revision : 1.0
// ============================================================================
module mem_fill_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LATENCY = 4,
    parameter int RR_MODE     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          req_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]          stall_out,
    output logic [NUM_PORTS-1:0]          fill_we,
    output logic [DATA_W-1:0]             fill_data,
    output logic [ADDR_W-1:0]             fill_addr,
    output logic                          mem_en,
    output logic                          mem_wr,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int GW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int IW  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int OFF = $clog2(BLOCK_WORDS * 2);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));
    localparam logic [IW-1:0]     LAST_IDX  = IW'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [GW-1:0]                   gnt_q, gnt_d;
    logic [GW-1:0]                   ptr_q, ptr_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [DATA_W-1:0]               wdata_q, wdata_d;
    logic [IW-1:0]                   issue_q, issue_d;
    logic [MEM_LATENCY-1:0]          vld_q, vld_d;
    logic [MEM_LATENCY-1:0][IW-1:0]  idx_q, idx_d;

    logic [GW-1:0]      arb_gnt;
    logic               arb_found;
    logic [GW-1:0]      arb_start;
    logic [GW-1:0]      cand;
    logic               sel_wr;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               issue;
    logic               ret_vld;
    logic [IW-1:0]      ret_idx;
    logic               done;
    logic [ADDR_W-1:0]  base;

    assign base    = addr_q & BASE_MASK;
    assign ret_vld = vld_q[MEM_LATENCY-1];
    assign ret_idx = idx_q[MEM_LATENCY-1];

    // Fixed priority is round-robin with the search always starting at port 0.
    always_comb begin
        arb_gnt   = '0;
        arb_found = 1'b0;
        cand      = '0;
        arb_start = (RR_MODE != 0) ? ptr_q : '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = GW'((int'(arb_start) + k) % NUM_PORTS);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_gnt   = cand;
            end
        end
    end

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (arb_gnt == GW'(p)) begin
                sel_wr    = req_wr[p];
                sel_addr  = req_addr[p*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[p*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        issue_d   = issue_q;
        issue     = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_d   = arb_gnt;
                    ptr_d   = (arb_gnt == GW'(NUM_PORTS - 1)) ? '0 : arb_gnt + GW'(1);
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    issue_d = '0;
                    state_d = sel_wr ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                state_d   = S_IDLE;
            end
            S_READ: begin
                issue    = 1'b1;
                mem_en   = 1'b1;
                mem_addr = base + (ADDR_W'(issue_q) << 1);
                if (issue_q == LAST_IDX) begin
                    issue_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    issue_d = issue_q + IW'(1);
                end
            end
            S_DRAIN: begin
                if (ret_vld && (ret_idx == LAST_IDX)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Return pipe: a word issued in cycle t reaches the last stage in t+MEM_LATENCY.
    always_comb begin
        vld_d    = '0;
        idx_d    = '0;
        vld_d[0] = issue;
        idx_d[0] = issue_q;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            issue_q <= '0;
            vld_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            issue_q <= issue_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
        end
    end

    assign done      = (state_q == S_WRITE) | (ret_vld & (ret_idx == LAST_IDX));
    assign stall_out = req & ~(NUM_PORTS'(done) << gnt_q);
    assign fill_we   = NUM_PORTS'(ret_vld) << gnt_q;
    assign fill_data = ret_vld ? mem_rdata : '0;
    assign fill_addr = ret_vld ? (base + (ADDR_W'(ret_idx) << 1)) : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_fill_arbiter
// Brief    : Directed bench for mem_fill_arbiter (fixed-priority and RR copies).
// Revision : 1.0
// ============================================================================
module tb_mem_fill_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [15:0] mem_rdata;

    logic [1:0]  f_stall, f_fwe, r_stall, r_fwe;
    logic [15:0] f_fdata, f_faddr, f_maddr, f_mwdata;
    logic [15:0] r_fdata, r_faddr, r_maddr, r_mwdata;
    logic        f_men, f_mwr, r_men, r_mwr;

    int checks;
    int failures;

    mem_fill_arbiter #(.NUM_PORTS(2), .ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8),
                       .MEM_LATENCY(4), .RR_MODE(0)) u_fixed (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall_out(f_stall), .fill_we(f_fwe),
        .fill_data(f_fdata), .fill_addr(f_faddr), .mem_en(f_men), .mem_wr(f_mwr),
        .mem_addr(f_maddr), .mem_wdata(f_mwdata), .mem_rdata(mem_rdata)
    );

    mem_fill_arbiter #(.NUM_PORTS(2), .ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8),
                       .MEM_LATENCY(4), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall_out(r_stall), .fill_we(r_fwe),
        .fill_data(r_fdata), .fill_addr(r_faddr), .mem_en(r_men), .mem_wr(r_mwr),
        .mem_addr(r_maddr), .mem_wdata(r_mwdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req    = 2'($urandom);
            req_wr = 2'($urandom);
            tick();
            #3;
            if (i > 0) begin
                check_eq($sformatf("rst_men_%0d", i),   32'(f_men), 32'h0);
                check_eq($sformatf("rst_fwe_%0d", i),   32'(f_fwe), 32'h0);
                check_eq($sformatf("rst_maddr_%0d", i), 32'(f_maddr), 32'h0);
                check_eq($sformatf("rst_stall_%0d", i), 32'(f_stall), 32'(req));
                check_eq($sformatf("rst_rrstall_%0d", i), 32'(r_stall), 32'(req));
            end
        end
        req = 2'b00;
        rst = 1'b0;
        tick();
    endtask

    // Block read from port p; requester drops req in cycle drop_c (or on completion).
    task automatic do_read(input int p, input logic [15:0] a, input int drop_c);
        logic [15:0] base;
        logic [1:0]  pm;
        logic [15:0] exp_word;
        bit          in_fill;
        base   = a & 16'hFFF0;
        pm     = 2'b01 << p;
        req_wr = 2'b00;
        req_addr[p*16 +: 16] = a;
        req    = pm;
        for (int c = 0; c <= 13; c++) begin
            if (c == drop_c || c == 13) req = 2'b00;
            in_fill   = (c >= 5) && (c <= 12);
            exp_word  = (base + 16'(2 * (c - 5))) ^ 16'hA5A5;
            mem_rdata = in_fill ? exp_word : 16'h0;
            #3;
            check_eq($sformatf("rd_men_c%0d", c), 32'(f_men), 32'((c >= 1) && (c <= 8)));
            check_eq($sformatf("rd_maddr_c%0d", c), 32'(f_maddr),
                     (c >= 1 && c <= 8) ? 32'(base + 16'(2 * (c - 1))) : 32'h0);
            check_eq($sformatf("rd_fwe_c%0d", c), 32'(f_fwe), in_fill ? 32'(pm) : 32'h0);
            check_eq($sformatf("rd_faddr_c%0d", c), 32'(f_faddr),
                     in_fill ? 32'(base + 16'(2 * (c - 5))) : 32'h0);
            check_eq($sformatf("rd_fdata_c%0d", c), 32'(f_fdata), in_fill ? 32'(exp_word) : 32'h0);
            check_eq($sformatf("rd_stall_c%0d", c), 32'(f_stall),
                     32'(req & ~((c == 12) ? pm : 2'b00)));
            tick();
        end
        mem_rdata = 16'h0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        req       = 2'b00;
        req_wr    = 2'b00;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        mem_rdata = 16'h0;

        // Reset with random requests, then contention with back-to-back writes.
        do_reset();
        req       = 2'b11;
        req_wr    = 2'b11;
        req_addr  = {16'h2000, 16'h1000};
        req_wdata = {16'h2222, 16'h1111};
        for (int c = 0; c < 8; c++) begin
            #3;
            check_eq($sformatf("fx_men_c%0d", c), 32'(f_men), 32'(c % 2));
            check_eq($sformatf("fx_maddr_c%0d", c), 32'(f_maddr), (c % 2 == 1) ? 32'h1000 : 32'h0);
            check_eq($sformatf("fx_stall_c%0d", c), 32'(f_stall), (c % 2 == 1) ? 32'h2 : 32'h3);
            check_eq($sformatf("rr_maddr_c%0d", c), 32'(r_maddr),
                     (c % 2 == 0) ? 32'h0 : ((c % 4 == 1) ? 32'h1000 : 32'h2000));
            check_eq($sformatf("rr_mwdata_c%0d", c), 32'(r_mwdata),
                     (c % 2 == 0) ? 32'h0 : ((c % 4 == 1) ? 32'h1111 : 32'h2222));
            check_eq($sformatf("rr_stall_c%0d", c), 32'(r_stall),
                     (c % 2 == 0) ? 32'h3 : ((c % 4 == 1) ? 32'h2 : 32'h1));
            tick();
        end
        req = 2'b00;
        tick();

        // Port 1 block read at an unaligned address.
        do_read(1, 16'h0036, 99);

        // Reset in cycle 6 of a read kills the remaining fills.
        req_wr = 2'b00;
        req_addr[15:0] = 16'h0100;
        req = 2'b01;
        for (int c = 0; c < 6; c++) tick();
        rst = 1'b1;
        req = 2'b00;
        tick();
        rst = 1'b0;
        for (int c = 7; c <= 12; c++) begin
            #3;
            check_eq($sformatf("rstmid_fwe_c%0d", c), 32'(f_fwe), 32'h0);
            check_eq($sformatf("rstmid_men_c%0d", c), 32'(f_men), 32'h0);
            tick();
        end
        do_read(0, 16'h0104, 99);

        // Requester abandons req in cycle 3; fill still completes.
        do_read(0, 16'h0200, 3);

        // Single write from port 0, granted straight out of the previous read.
        req_wr = 2'b01;
        req_addr[15:0]  = 16'h1000;
        req_wdata[15:0] = 16'hBEEF;
        req = 2'b01;
        #3;
        check_eq("wr_stall_c0", 32'(f_stall), 32'h1);
        check_eq("wr_men_c0", 32'(f_men), 32'h0);
        tick();
        #3;
        check_eq("wr_men_c1", 32'(f_men), 32'h1);
        check_eq("wr_mwr_c1", 32'(f_mwr), 32'h1);
        check_eq("wr_maddr_c1", 32'(f_maddr), 32'h1000);
        check_eq("wr_mwdata_c1", 32'(f_mwdata), 32'hBEEF);
        check_eq("wr_stall_c1", 32'(f_stall), 32'h0);
        check_eq("wr_fwe_c1", 32'(f_fwe), 32'h0);
        tick();
        req = 2'b00;
        #3;
        check_eq("wr_men_c2", 32'(f_men), 32'h0);
        check_eq("wr_fwe_c2", 32'(f_fwe), 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
